// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// opcode classes and datapath select codes. Honours CONTROL_JAL_EN.
package control_pkg;

  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_LW, C_SW, C_ADDI, C_R, C_BEQ, C_JAL, C_ILL
  } opc_t;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_RF  = 2'b10;
  localparam logic [1:0] ULA_IF  = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] WB_ULA = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic opc_t classify(input logic [6:0] op);
    opc_t c;
    case (op)
      OPC_LW:   c = C_LW;
      OPC_SW:   c = C_SW;
      OPC_ADDI: c = C_ADDI;
      OPC_R:    c = C_R;
      OPC_BEQ:  c = C_BEQ;
`ifdef CONTROL_JAL_EN
      OPC_JAL:  c = C_JAL;
`endif
      default:  c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired when the count reaches MEM_TIMEOUT
// while ready is low. Ports: clk, rst_n, start (clear), ready, expired.
module mem_wait_timer
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIM = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt;

  // Saturates at the limit; past it the FSM has already left for ERROR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (!ready && cnt != LIM) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (cnt == LIM) && !ready;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory-ready handshake, timeout, sticky err and retire counter.
// Inputs: clk, rst_n, Opcode, zero, mem_ready. Outputs: datapath enables
// and selects, state_o, err, instr_count. CONTROL_JAL_EN enables jal.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             ULASrc,
  output logic [1:0]       ULAOp,
  output logic [2:0]       state_o,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_t st, st_n;
  opc_t   opq, dec;
  logic   expired, start, retire;

  assign dec = classify(Opcode);

  // Timer restarts whenever FETCH or MEM is freshly entered.
  assign start  = (st_n != st) &&
                  (st_n == S_FETCH || st_n == S_MEM);
  assign retire = (st != S_FETCH) && (st_n == S_FETCH);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ready   (mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_FETCH;
      opq         <= C_ILL;
      instr_count <= '0;
    end else begin
      st <= st_n;
      if (st == S_DECODE) opq <= dec;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    st_n     = st;
    PCWrite  = 1'b0;
    PCSrc    = PC_SEQ;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = WB_ULA;
    RegWrite = 1'b0;
    ULASrc   = 1'b0;
    ULAOp    = ULA_ADD;
    err      = 1'b0;

    case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          st_n    = S_DECODE;
        end else if (expired) begin
          st_n = S_ERROR;
        end
      end

      S_DECODE: begin
        st_n = (dec == C_ILL) ? S_ERROR : S_EXEC;
      end

      S_EXEC: begin
        unique case (1'b1)
          (opq == C_LW) || (opq == C_SW): begin
            ULASrc = 1'b1;
            ULAOp  = ULA_ADD;
            st_n   = S_MEM;
          end
          (opq == C_ADDI): begin
            ULASrc = 1'b1;
            ULAOp  = ULA_IF;
            st_n   = S_WB;
          end
          (opq == C_R): begin
            ULAOp = ULA_RF;
            st_n  = S_WB;
          end
          (opq == C_BEQ): begin
            ULAOp   = ULA_SUB;
            PCSrc   = PC_BR;
            PCWrite = zero;
            st_n    = S_FETCH;
          end
`ifdef CONTROL_JAL_EN
          (opq == C_JAL): begin
            PCSrc   = PC_JMP;
            PCWrite = 1'b1;
            st_n    = S_WB;
          end
`endif
          default: st_n = S_ERROR;
        endcase
      end

      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (opq == C_LW);
        MemWrite = (opq == C_SW);
        if (mem_ready) begin
          st_n = (opq == C_LW) ? S_WB : S_FETCH;
        end else if (expired) begin
          st_n = S_ERROR;
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (opq == C_LW) ? WB_MEM : WB_ULA;
`ifdef CONTROL_JAL_EN
        if (opq == C_JAL) MemtoReg = WB_PC4;
`endif
        st_n = S_FETCH;
      end

      S_ERROR: begin
        err = 1'b1;
      end

      default: st_n = S_ERROR;
    endcase

    // Reset holds every output at its idle value, even in FETCH.
    if (!rst_n) begin
      PCWrite  = 1'b0;
      PCSrc    = PC_SEQ;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = WB_ULA;
      RegWrite = 1'b0;
      ULASrc   = 1'b0;
      ULAOp    = ULA_ADD;
      err      = 1'b0;
    end
  end

  assign state_o = st;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=4).
// Covers lw/sw/beq/addi/R, waits, timeouts, illegal/jal and async reset.
module tb_multicycle_control_unit;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  Opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        IRWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemtoReg;
  logic        RegWrite;
  logic        ULASrc;
  logic [1:0]  ULAOp;
  logic [2:0]  state_o;
  logic        err;
  logic [31:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_control_unit #(
    .MEM_TIMEOUT(4),
    .CNT_W(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Opcode      (Opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCSrc       (PCSrc),
    .IRWrite     (IRWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ULASrc      (ULASrc),
    .ULAOp       (ULAOp),
    .state_o     (state_o),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic rdy, input logic z,
                      input logic [6:0] op);
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    Opcode    = op;
    #1;
  endtask

  task automatic rst_go(input logic rdy, input logic [6:0] op);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = rdy;
    zero      = 1'b0;
    Opcode    = op;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    Opcode    = 7'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", instr_count, 32'd0);

    // lw, zero-wait memory
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; Opcode = LW;
    #1;
    chk("lw_f_state", 32'(state_o), 32'd0);
    chk("lw_f_memread", 32'(MemRead), 32'd1);
    chk("lw_f_iord", 32'(IorD), 32'd0);
    chk("lw_f_irwrite", 32'(IRWrite), 32'd1);
    chk("lw_f_pcwrite", 32'(PCWrite), 32'd1);
    chk("lw_f_pcsrc", 32'(PCSrc), 32'd0);
    step(1, 0, LW);
    chk("lw_d_state", 32'(state_o), 32'd1);
    chk("lw_d_memread", 32'(MemRead), 32'd0);
    step(1, 0, LW);
    chk("lw_e_state", 32'(state_o), 32'd2);
    chk("lw_e_ulasrc", 32'(ULASrc), 32'd1);
    chk("lw_e_ulaop", 32'(ULAOp), 32'd0);
    step(1, 0, LW);
    chk("lw_m_state", 32'(state_o), 32'd3);
    chk("lw_m_iord", 32'(IorD), 32'd1);
    chk("lw_m_memread", 32'(MemRead), 32'd1);
    chk("lw_m_memwrite", 32'(MemWrite), 32'd0);
    step(1, 0, LW);
    chk("lw_w_state", 32'(state_o), 32'd4);
    chk("lw_w_regwrite", 32'(RegWrite), 32'd1);
    chk("lw_w_memtoreg", 32'(MemtoReg), 32'd1);
    chk("lw_w_cnt", instr_count, 32'd0);
    step(1, 0, BEQ);
    chk("lw_ret_state", 32'(state_o), 32'd0);
    chk("lw_ret_cnt", instr_count, 32'd1);

    // beq taken
    step(1, 1, BEQ);
    chk("beq1_d_state", 32'(state_o), 32'd1);
    step(1, 1, BEQ);
    chk("beq1_e_state", 32'(state_o), 32'd2);
    chk("beq1_pcwrite", 32'(PCWrite), 32'd1);
    chk("beq1_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq1_ulaop", 32'(ULAOp), 32'd1);
    step(1, 0, BEQ);
    chk("beq1_ret_state", 32'(state_o), 32'd0);
    chk("beq1_cnt", instr_count, 32'd2);

    // beq not taken
    step(1, 0, BEQ);
    step(1, 0, BEQ);
    chk("beq0_pcwrite", 32'(PCWrite), 32'd0);
    chk("beq0_pcsrc", 32'(PCSrc), 32'd1);
    step(1, 0, SW);
    chk("beq0_cnt", instr_count, 32'd3);

    // sw with 3 wait cycles in MEM
    step(1, 0, SW);
    step(1, 0, SW);
    chk("sw_e_ulasrc", 32'(ULASrc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 0, SW);
      chk($sformatf("sw_m%0d_state", i), 32'(state_o), 32'd3);
      chk($sformatf("sw_m%0d_memwrite", i), 32'(MemWrite), 32'd1);
      chk($sformatf("sw_m%0d_iord", i), 32'(IorD), 32'd1);
      chk($sformatf("sw_m%0d_regwrite", i), 32'(RegWrite), 32'd0);
    end
    step(1, 0, ADDI);
    chk("sw_ret_state", 32'(state_o), 32'd0);
    chk("sw_ret_regwrite", 32'(RegWrite), 32'd0);
    chk("sw_cnt", instr_count, 32'd4);

    // addi
    step(1, 0, ADDI);
    step(1, 0, ADDI);
    chk("addi_e_ulasrc", 32'(ULASrc), 32'd1);
    chk("addi_e_ulaop", 32'(ULAOp), 32'd3);
    step(1, 0, ADDI);
    chk("addi_w_regwrite", 32'(RegWrite), 32'd1);
    chk("addi_w_memtoreg", 32'(MemtoReg), 32'd0);
    step(1, 0, RT);
    chk("addi_cnt", instr_count, 32'd5);

    // R-type; its retire cycle starts a FETCH with ready stuck low
    step(1, 0, RT);
    step(1, 0, RT);
    chk("r_e_ulasrc", 32'(ULASrc), 32'd0);
    chk("r_e_ulaop", 32'(ULAOp), 32'd2);
    step(1, 0, RT);
    chk("r_w_regwrite", 32'(RegWrite), 32'd1);
    step(0, 0, ADDI);
    chk("r_cnt", instr_count, 32'd6);

    // FETCH timeout: 5 wait cycles then ERROR
    for (int i = 0; i < 4; i++) begin
      step(0, 0, ADDI);
      chk($sformatf("to_f%0d_state", i), 32'(state_o), 32'd0);
    end
    step(0, 0, ADDI);
    chk("to_err_state", 32'(state_o), 32'd7);
    chk("to_err_flag", 32'(err), 32'd1);
    chk("to_err_memread", 32'(MemRead), 32'd0);
    step(1, 0, ADDI);
    chk("to_hold_state", 32'(state_o), 32'd7);
    chk("to_hold_irwrite", 32'(IRWrite), 32'd0);
    chk("to_hold_pcwrite", 32'(PCWrite), 32'd0);
    chk("to_hold_err", 32'(err), 32'd1);

    // ready rises on the 5th FETCH cycle: no error
    rst_go(0, ADDI);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_cnt", instr_count, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, ADDI);
    step(1, 0, ADDI);
    chk("late_irwrite", 32'(IRWrite), 32'd1);
    chk("late_state", 32'(state_o), 32'd0);
    step(1, 0, ADDI);
    chk("late_d_state", 32'(state_o), 32'd1);
    chk("late_d_err", 32'(err), 32'd0);
    step(1, 0, ADDI);
    step(1, 0, ADDI);
    step(1, 0, JAL);
    chk("late_cnt", instr_count, 32'd1);

    // jal
    step(1, 0, JAL);
    step(1, 0, JAL);
`ifdef CONTROL_JAL_EN
    chk("jal_e_state", 32'(state_o), 32'd2);
    chk("jal_e_pcsrc", 32'(PCSrc), 32'd2);
    chk("jal_e_pcwrite", 32'(PCWrite), 32'd1);
    step(1, 0, JAL);
    chk("jal_w_memtoreg", 32'(MemtoReg), 32'd2);
    chk("jal_w_regwrite", 32'(RegWrite), 32'd1);
    step(1, 0, JAL);
    chk("jal_cnt", instr_count, 32'd2);
`else
    chk("jal_ill_state", 32'(state_o), 32'd7);
    chk("jal_ill_err", 32'(err), 32'd1);
    chk("jal_ill_pcsrc", 32'(PCSrc), 32'd0);
`endif

    // generic illegal opcode
    rst_go(1, BAD);
    step(1, 0, BAD);
    chk("ill_d_state", 32'(state_o), 32'd1);
    step(1, 0, BAD);
    chk("ill_state", 32'(state_o), 32'd7);
    chk("ill_err", 32'(err), 32'd1);

    // async reset in the middle of lw MEM
    rst_go(1, LW);
    step(1, 0, LW);
    step(1, 0, LW);
    step(0, 0, LW);
    chk("mr_m_state", 32'(state_o), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_state", 32'(state_o), 32'd0);
    chk("mr_memread", 32'(MemRead), 32'd0);
    chk("mr_iord", 32'(IorD), 32'd0);
    chk("mr_cnt", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; Opcode = LW;
    #1;
    chk("mr_rel_memread", 32'(MemRead), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0, LW);
    chk("mr_w_state", 32'(state_o), 32'd4);
    step(1, 0, LW);
    chk("mr_cnt1", instr_count, 32'd1);

    // MEM timeout on lw
    step(1, 0, LW);
    step(1, 0, LW);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, LW);
      chk($sformatf("mto_m%0d_state", i), 32'(state_o), 32'd3);
    end
    step(0, 0, LW);
    chk("mto_state", 32'(state_o), 32'd7);
    chk("mto_err", 32'(err), 32'd1);
    chk("mto_iord", 32'(IorD), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
